// File: rtl/icache_refill_unit_pkg.sv
// Shared types, geometry constants and the block-align helper
// for the instruction-cache refill unit.
package icache_refill_unit_pkg;

   localparam int PKG_SIZE_PC     = 32;
   localparam int PKG_CACHE_WIDTH = 256;
   localparam int PKG_MEM_WIDTH   = 64;

   localparam int BEATS       = PKG_CACHE_WIDTH / PKG_MEM_WIDTH;
   localparam int BLOCK_BYTES = PKG_CACHE_WIDTH / 8;
   localparam int OFF_BITS    = $clog2(BLOCK_BYTES);
   localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      FILL,
      WRITE,
      HOLD
   } state_e;

   function automatic logic [PKG_SIZE_PC-1:0] block_align(
      input logic [PKG_SIZE_PC-1:0] a
   );
      return {a[PKG_SIZE_PC-1:OFF_BITS], {OFF_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/icache_refill_unit_if.sv
// Miss / memory / cache-write bundle of the refill unit.
// slave = refill unit, master = cache plus memory side.
interface icache_refill_unit_if
   import icache_refill_unit_pkg::*;
#(
   parameter int SIZE_PC     = PKG_SIZE_PC,
   parameter int CACHE_WIDTH = PKG_CACHE_WIDTH,
   parameter int MEM_WIDTH   = PKG_MEM_WIDTH
);

   logic                   miss_i;
   logic [SIZE_PC-1:0]     missAddr_i;
   logic                   memReq_o;
   logic [SIZE_PC-1:0]     memAddr_o;
   logic                   memGnt_i;
   logic                   memRespValid_i;
   logic [MEM_WIDTH-1:0]   memRespData_i;
   logic                   wrEnable_o;
   logic [SIZE_PC-1:0]     wrAddr_o;
   logic [CACHE_WIDTH-1:0] instBlock_o;
   logic                   busy_o;

   modport slave (
      input  miss_i,
      input  missAddr_i,
      input  memGnt_i,
      input  memRespValid_i,
      input  memRespData_i,
      output memReq_o,
      output memAddr_o,
      output wrEnable_o,
      output wrAddr_o,
      output instBlock_o,
      output busy_o
   );

   modport master (
      output miss_i,
      output missAddr_i,
      output memGnt_i,
      output memRespValid_i,
      output memRespData_i,
      input  memReq_o,
      input  memAddr_o,
      input  wrEnable_o,
      input  wrAddr_o,
      input  instBlock_o,
      input  busy_o
   );

endinterface

// File: rtl/icache_refill_unit_beat_assembler.sv
// Beat counter and insert register that builds one cache block
// from memory beats; beat 0 lands in the lowest bits.
module refill_beat_assembler
   import icache_refill_unit_pkg::*;
#(
   parameter int CACHE_WIDTH = PKG_CACHE_WIDTH,
   parameter int MEM_WIDTH   = PKG_MEM_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear_i,
   input  logic                   beat_valid_i,
   input  logic [MEM_WIDTH-1:0]   beat_data_i,
   output logic                   last_o,
   output logic [CACHE_WIDTH-1:0] block_o
);

   localparam int NB = CACHE_WIDTH / MEM_WIDTH;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          cnt_d;
   logic [CACHE_WIDTH-1:0] blk_q;
   logic [CACHE_WIDTH-1:0] blk_d;

   assign last_o  = beat_valid_i && (cnt_q == CW'(NB - 1));
   assign block_o = blk_q;

   // Counter wraps to zero on the last beat.
   always_comb begin
      cnt_d = cnt_q;
      blk_d = blk_q;
      if (clear_i) begin
         cnt_d = '0;
         blk_d = '0;
      end else if (beat_valid_i) begin
         blk_d[cnt_q*MEM_WIDTH +: MEM_WIDTH] = beat_data_i;
         cnt_d = last_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         blk_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         blk_q <= blk_d;
      end
   end

endmodule

// File: rtl/icache_refill_unit.sv
// L1 I-cache miss refill FSM: request, assemble, write back.
// Optional next-line prefetch: ICACHE_REFILL_PREFETCH_EN.
module icache_refill_unit
   import icache_refill_unit_pkg::*;
#(
   parameter int SIZE_PC     = PKG_SIZE_PC,
   parameter int CACHE_WIDTH = PKG_CACHE_WIDTH,
   parameter int MEM_WIDTH   = PKG_MEM_WIDTH
) (
   input logic                 clk,
   input logic                 reset,
   icache_refill_unit_if.slave bus
);

   if (SIZE_PC != PKG_SIZE_PC ||
       CACHE_WIDTH != PKG_CACHE_WIDTH ||
       MEM_WIDTH != PKG_MEM_WIDTH ||
       CACHE_WIDTH % MEM_WIDTH != 0) begin : g_bad_geom
      $error("refill geometry must match package");
   end

   state_e             state_q;
   state_e             state_d;
   logic [SIZE_PC-1:0] addr_q;
   logic [SIZE_PC-1:0] addr_d;
   logic               req_q;
   logic               req_d;
   logic               wr_q;
   logic               wr_d;
   logic               pf_q;
   logic               pf_d;
   logic               clr;
   logic               beat_vld;
   logic               last;

   assign beat_vld = (state_q == FILL) && bus.memRespValid_i;

   refill_beat_assembler #(
      .CACHE_WIDTH (CACHE_WIDTH),
      .MEM_WIDTH   (MEM_WIDTH)
   ) u_asm (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (clr),
      .beat_valid_i (beat_vld),
      .beat_data_i  (bus.memRespData_i),
      .last_o       (last),
      .block_o      (bus.instBlock_o)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      req_d   = req_q;
      wr_d    = 1'b0;
      pf_d    = pf_q;
      clr     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.miss_i) begin
               state_d = REQ;
               addr_d  = block_align(bus.missAddr_i);
               req_d   = 1'b1;
               pf_d    = 1'b0;
            end
         end
         REQ: begin
            if (bus.memGnt_i) begin
               state_d = FILL;
               req_d   = 1'b0;
               clr     = 1'b1;
            end
         end
         FILL: begin
            if (last) begin
               state_d = WRITE;
               wr_d    = 1'b1;
            end
         end
         WRITE: state_d = HOLD;
         // HOLD keeps miss_i out so the cache sees the new block first.
         HOLD: begin
            state_d = IDLE;
            pf_d    = 1'b0;
`ifdef ICACHE_REFILL_PREFETCH_EN
            if (!pf_q && !bus.miss_i) begin
               state_d = REQ;
               addr_d  = addr_q + SIZE_PC'(BLOCK_BYTES);
               req_d   = 1'b1;
               pf_d    = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         req_q   <= 1'b0;
         wr_q    <= 1'b0;
         pf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         wr_q    <= wr_d;
         pf_q    <= pf_d;
      end
   end

   assign bus.memReq_o   = req_q;
   assign bus.memAddr_o  = addr_q;
   assign bus.wrEnable_o = wr_q;
   assign bus.wrAddr_o   = addr_q;
   assign bus.busy_o     = (state_q != IDLE);

endmodule
